mem_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline register in the five-stage MIPS core.
- Decodes the load/store in the instruction held in EX/MEM and drives the external data-memory port (address, write data, byte enables).
- Extracts and sign- or zero-extends load data, then registers PC, Instr, WriteReg and write-back data into MEM/WB.
- Flags misaligned accesses with a sticky error bit and a saturating counter.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_load_ext.sv | 28 ++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: opcodes, reset values and the load-type decode.
// Pure definitions; no logic, no latency, no backpressure.
package mem_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_RESET      = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO         = 5'd0;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_W,
        LD_H,
        LD_HU,
        LD_B,
        LD_BU
    } ld_type_t;

    function automatic ld_type_t decode_load(input logic [5:0] op);
        case (op)
            OP_LW:   return LD_W;
            OP_LH:   return LD_H;
            OP_LHU:  return LD_HU;
            OP_LB:   return LD_B;
            OP_LBU:  return LD_BU;
            default: return LD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: selects the byte/halfword lane and sign- or zero-extends it.
// Purely combinational; no backpressure.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  ld_type_t    ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{a, 3'b000} +: 8];
        half_lane = a[1] ? rdata[31:16] : rdata[15:0];
        case (ld_type)
            LD_W:    data = rdata;
            LD_H:    data = {{16{half_lane[15]}}, half_lane};
            LD_HU:   data = {16'h0000, half_lane};
            LD_B:    data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   data = {24'h00_0000, byte_lane};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory port combinationally and registers MEM/WB (1 cycle).
// No backpressure: MEM/WB updates every cycle, stalls arrive upstream as bubbles.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         m_PC,
    input  logic [31:0]         m_Instr,
    input  logic [4:0]          m_WriteReg,
    input  logic [31:0]         m_Eout,
    input  logic [31:0]         m_RD2,
    input  logic [31:0]         m_data_rdata,
    output logic [31:0]         m_data_addr,
    output logic [31:0]         m_data_wdata,
    output logic [3:0]          m_data_byteen,
    output logic [31:0]         m_inst_addr,
    output logic [31:0]         MEMWB_PC,
    output logic [31:0]         MEMWB_Instr,
    output logic [4:0]          MEMWB_WriteReg,
    output logic [31:0]         MEMWB_Wdata,
    output logic                align_err,
    output logic [ERRCNT_W-1:0] align_err_cnt
);

    logic [5:0]  op;
    logic [1:0]  a;
    ld_type_t    ld_type;
    logic        is_load;
    logic        word_acc;
    logic        half_acc;
    logic        misalign;
    logic [31:0] load_data;

    assign op          = m_Instr[31:26];
    assign a           = m_Eout[1:0];
    assign m_data_addr = {m_Eout[31:2], 2'b00};
    assign m_inst_addr = m_PC;

    always_comb begin
        ld_type  = decode_load(op);
        is_load  = (ld_type != LD_NONE);
        word_acc = (op == OP_LW) || (op == OP_SW);
        half_acc = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        misalign = (word_acc && (a != 2'b00)) || (half_acc && a[0]);
    end

    // Store data is replicated across lanes; the byte enables pick the live lane.
    always_comb begin
        m_data_byteen = 4'b0000;
        m_data_wdata  = 32'h0000_0000;
        case (op)
            OP_SW: begin
                m_data_byteen = 4'b1111;
                m_data_wdata  = m_RD2;
            end
            OP_SH: begin
                m_data_byteen = 4'b0011 << a;
                m_data_wdata  = {2{m_RD2[15:0]}};
            end
            OP_SB: begin
                m_data_byteen = 4'b0001 << a;
                m_data_wdata  = {4{m_RD2[7:0]}};
            end
            default: ;
        endcase
        if (misalign) begin
            m_data_byteen = 4'b0000;
        end
    end

    load_ext u_load_ext (
        .rdata   (m_data_rdata),
        .a       (a),
        .ld_type (ld_type),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            MEMWB_PC       <= PC_RESET;
            MEMWB_Instr    <= INSTR_RESET;
            MEMWB_WriteReg <= REG_ZERO;
            MEMWB_Wdata    <= 32'h0000_0000;
            align_err      <= 1'b0;
            align_err_cnt  <= '0;
        end else begin
            MEMWB_PC    <= m_PC;
            MEMWB_Instr <= m_Instr;
            // A misaligned load must not retire a write to the register file.
            if (is_load && misalign) begin
                MEMWB_WriteReg <= REG_ZERO;
                MEMWB_Wdata    <= 32'h0000_0000;
            end else begin
                MEMWB_WriteReg <= m_WriteReg;
                MEMWB_Wdata    <= is_load ? load_data : m_Eout;
            end
            if (misalign) begin
                align_err <= 1'b1;
                if (!(&align_err_cnt)) begin
                    align_err_cnt <= align_err_cnt + ERRCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed plan steps plus random traffic against a behavioural model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_PC, m_Instr, m_Eout, m_RD2, m_data_rdata;
    logic [4:0]  m_WriteReg;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] MEMWB_PC, MEMWB_Instr, MEMWB_Wdata;
    logic [4:0]  MEMWB_WriteReg;
    logic        align_err;
    logic [7:0]  align_err_cnt;

    int checks = 0;
    int errors = 0;
    bit m_err;
    int m_cnt;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .m_PC           (m_PC),
        .m_Instr        (m_Instr),
        .m_WriteReg     (m_WriteReg),
        .m_Eout         (m_Eout),
        .m_RD2          (m_RD2),
        .m_data_rdata   (m_data_rdata),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .MEMWB_PC       (MEMWB_PC),
        .MEMWB_Instr    (MEMWB_Instr),
        .MEMWB_WriteReg (MEMWB_WriteReg),
        .MEMWB_Wdata    (MEMWB_Wdata),
        .align_err      (align_err),
        .align_err_cnt  (align_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = op;
        return r;
    endfunction

    // One cycle: drive inputs, check memory port, clock, check MEM/WB and error state.
    task automatic step(input bit rst, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] wr, input logic [31:0] eout,
                        input logic [31:0] rd2, input logic [31:0] rdata);
        int          width;
        int          a;
        bit          ld, st, sgn, misal;
        logic [31:0] mask, raw, lval, e_wd, e_wdat, e_pc, e_in;
        logic [3:0]  e_be;
        logic [4:0]  e_wr;

        ld = 0; st = 0; sgn = 0; width = 0;
        case (instr[31:26])
            6'h23: begin ld = 1; width = 4; end
            6'h21: begin ld = 1; width = 2; sgn = 1; end
            6'h25: begin ld = 1; width = 2; end
            6'h20: begin ld = 1; width = 1; sgn = 1; end
            6'h24: begin ld = 1; width = 1; end
            6'h2b: begin st = 1; width = 4; end
            6'h29: begin st = 1; width = 2; end
            6'h28: begin st = 1; width = 1; end
            default: ;
        endcase
        a     = int'(eout & 32'd3);
        misal = (ld || st) && ((a % width) != 0);
        mask  = (width == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * width)) - 32'd1);

        e_be   = 4'b0000;
        e_wdat = 32'h0;
        if (st) begin
            for (int i = 0; i < 4 / width; i++) e_wdat |= (rd2 & mask) << (8 * width * i);
            if (!misal) e_be = 4'(((1 << width) - 1) << a);
        end
        lval = 32'h0;
        if (ld) begin
            raw  = (rdata >> (8 * (a - a % width))) & mask;
            lval = (sgn && raw[8 * width - 1]) ? (raw | ~mask) : raw;
        end

        reset = rst; m_PC = pc; m_Instr = instr; m_WriteReg = wr;
        m_Eout = eout; m_RD2 = rd2; m_data_rdata = rdata;
        #2;
        chk("addr", m_data_addr, eout & 32'hFFFF_FFFC);
        chk("wdata", m_data_wdata, e_wdat);
        chk("byteen", {28'h0, m_data_byteen}, {28'h0, e_be});
        chk("inst_addr", m_inst_addr, pc);

        if (rst) begin
            e_pc = 32'h3000; e_in = 32'h0; e_wr = 5'd0; e_wd = 32'h0;
            m_err = 0; m_cnt = 0;
        end else begin
            e_pc = pc; e_in = instr;
            e_wr = (ld && misal) ? 5'd0 : wr;
            e_wd = ld ? (misal ? 32'h0 : lval) : eout;
            if (misal) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end

        @(posedge clk);
        #1;
        chk("memwb_pc", MEMWB_PC, e_pc);
        chk("memwb_instr", MEMWB_Instr, e_in);
        chk("memwb_wreg", {27'h0, MEMWB_WriteReg}, {27'h0, e_wr});
        chk("memwb_wdata", MEMWB_Wdata, e_wd);
        chk("align_err", {31'h0, align_err}, {31'h0, m_err});
        chk("align_err_cnt", {24'h0, align_err_cnt}, 32'(m_cnt));
    endtask

    initial begin
        logic [5:0]  ops [10];
        logic [31:0] ins, eo;

        ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28, 6'h00, 6'h0d};
        m_err = 0; m_cnt = 0;
        reset = 1; m_PC = 0; m_Instr = 0; m_WriteReg = 0; m_Eout = 0; m_RD2 = 0; m_data_rdata = 0;
        @(posedge clk);
        #1;

        // Reset with arbitrary (misaligned) traffic on the inputs.
        step(1, 32'h1234, mk(6'h2b), 5'd3, 32'h1, $urandom, $urandom);
        step(1, 32'h5678, mk(6'h23), 5'd4, 32'h2, $urandom, $urandom);
        chk("rst_pc", MEMWB_PC, 32'h0000_3000);
        chk("rst_instr", MEMWB_Instr, 32'h0);
        chk("rst_wreg", {27'h0, MEMWB_WriteReg}, 32'h0);
        chk("rst_wdata", MEMWB_Wdata, 32'h0);
        chk("rst_err", {31'h0, align_err}, 32'h0);
        chk("rst_cnt", {24'h0, align_err_cnt}, 32'h0);

        step(0, 32'h3000, mk(6'h28), 5'd0, 32'h6, 32'h1234_56AB, 32'h0);
        chk("sb_byteen", {28'h0, m_data_byteen}, 32'h4);
        chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
        chk("sb_addr", m_data_addr, 32'h4);
        chk("sb_memwb_wdata", MEMWB_Wdata, 32'h6);

        step(0, 32'h3004, mk(6'h20), 5'd9, 32'h3, 32'h0, 32'h80FF_0000);
        chk("lb_wdata", MEMWB_Wdata, 32'hFFFF_FF80);
        step(0, 32'h3008, mk(6'h24), 5'd9, 32'h3, 32'h0, 32'h80FF_0000);
        chk("lbu_wdata", MEMWB_Wdata, 32'h0000_0080);
        step(0, 32'h300C, mk(6'h21), 5'd10, 32'h2, 32'h0, 32'h8001_1234);
        chk("lh_wdata", MEMWB_Wdata, 32'hFFFF_8001);
        step(0, 32'h3010, mk(6'h25), 5'd10, 32'h2, 32'h0, 32'h8001_1234);
        chk("lhu_wdata", MEMWB_Wdata, 32'h0000_8001);

        step(0, 32'h3014, mk(6'h2b), 5'd0, 32'h2, 32'hDEAD_BEEF, 32'h0);
        chk("sw_mis_byteen", {28'h0, m_data_byteen}, 32'h0);
        step(0, 32'h3018, mk(6'h23), 5'd11, 32'h1, 32'h0, 32'hCAFE_F00D);
        chk("lw_mis_wreg", {27'h0, MEMWB_WriteReg}, 32'h0);
        chk("mis_err", {31'h0, align_err}, 32'h1);
        chk("mis_cnt", {24'h0, align_err_cnt}, 32'h2);
        step(1, 32'h301C, mk(6'h23), 5'd11, 32'h3, 32'h0, 32'h0);
        chk("clr_err", {31'h0, align_err}, 32'h0);
        chk("clr_cnt", {24'h0, align_err_cnt}, 32'h0);

        step(0, 32'h3020, 32'h0, 5'd0, 32'h7, 32'hFFFF_FFFF, 32'h0);
        chk("bubble_byteen", {28'h0, m_data_byteen}, 32'h0);
        chk("bubble_wdata", MEMWB_Wdata, 32'h7);
        chk("bubble_err", {31'h0, align_err}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            ins = mk(ops[$urandom_range(0, 9)]);
            if ($urandom_range(0, 15) == 0) ins = 32'h0;
            eo = $urandom;
            step($urandom_range(0, 39) == 0, $urandom, ins, 5'($urandom), eo, $urandom, $urandom);
        end

        for (int i = 0; i < 300; i++) begin
            step(0, 32'h4000 + 32'(4 * i), mk(6'h29), 5'd0, $urandom | 32'h1, $urandom, $urandom);
        end
        chk("sat_cnt", {24'h0, align_err_cnt}, 32'hFF);
        step(0, 32'h5000, {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20}, 5'd8, 32'h55, 32'h1, 32'h0);
        chk("add_wdata", MEMWB_Wdata, 32'h55);
        chk("add_wreg", {27'h0, MEMWB_WriteReg}, 32'h8);
        chk("add_byteen", {28'h0, m_data_byteen}, 32'h0);
        chk("add_cnt_held", {24'h0, align_err_cnt}, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
